mul_seq: RTL and testbench
==========================

# mul_seq

Iterative 32x32→64 multiply sequencer for the multi-cycle core. Accepts a UMULL/SMULL request from the controller and runs a radix-2 shift-add over a shared adder. It then sequences write-back of the low and high result words as two distinct cycles, asserting `WriteLo` and then `WriteHi` (the latter feeds the controller's `RegWriteHi` path). The controller holds its main FSM while `Busy` is high.

## Interface
- `MUL_W`, default 32: operand width. Product width is 2*MUL_W.
- `clk`  in  1: core clock. All state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `Start`  in  1: request pulse. Sampled only in IDLE.
- `Signed`  in  1: 1 = SMULL (two's complement), 0 = UMULL. Sampled with `Start`.
- `SrcA`  in  MUL_W: multiplicand. Sampled with `Start`.
- `SrcB`  in  MUL_W: multiplier. Sampled with `Start`.
- `Busy`  out  1: high from the cycle after acceptance through the WB_HI cycle.
- `WriteLo`  out  1: register-file write strobe for the low word. High only in WB_LO.
- `WriteHi`  out  1: register-file write strobe for the high word. High only in WB_HI.
- `Done`  out  1: one-cycle pulse, coincident with `WriteHi`.
- `ProdLo`  out  MUL_W: product bits [MUL_W-1:0].
- `ProdHi`  out  MUL_W: product bits [2*MUL_W-1:MUL_W].

## Operation
- States: IDLE, CALC, FIX, WB_LO, WB_HI.
- **IDLE**
  - On `Start`=1, load operands.
  - Signed=1: mc = zero-extended |SrcA| (64 bit), mb = |SrcB|, neg = SrcA[31]^SrcB[31].
  - Signed=0: raw operands, neg = 0.
  - Set acc = 0, cnt = MUL_W-1, then go to CALC.
  - |0x80000000| = 0x80000000, valid as an unsigned value.
- **CALC**, once per cycle:
  - If mb[0]=1, acc += mc (64-bit, no overflow is possible).
  - mc <<= 1; mb >>= 1; cnt -= 1.
  - Leave for FIX in the cycle where cnt = 0 (see Configuration for early exit).
- **FIX**: acc = neg ? (~acc + 1) : acc. Latch acc into ProdHi:ProdLo. Go to WB_LO.
- **WB_LO**: `WriteLo`=1, go to WB_HI.
- **WB_HI**: `WriteHi`=1, `Done`=1, go to IDLE.
- ProdLo/ProdHi are updated only in FIX. They hold their value until the next FIX or reset.
- `Start` while not in IDLE is ignored. No queuing.
- `Start` in the same cycle that the FSM returns to IDLE (i.e. during WB_HI) is ignored.
- Reset values: state IDLE; Busy, WriteLo, WriteHi, Done = 0; ProdLo, ProdHi = 0; internal acc, mc, mb, cnt, neg = 0.
- Reset in any state, including mid-CALC, returns to IDLE on the next edge. No write strobes follow.

## Timing
- T0: `Start` sampled high in IDLE.
- Without the early-exit macro:
  - CALC occupies T1–T32.
  - FIX at T33, WB_LO at T34, WB_HI/Done at T35.
  - IDLE at T36; a new `Start` can be accepted at T36.
- `Busy` is high T1–T35 and low at T0.
- Fixed latency without the macro: 35 cycles from Start to Done.
- Outputs are registered. No combinational path from any input to any output.

## Configuration
- `MUL_SEQ_EARLY_EXIT_EN` defined:
  - CALC also exits after any cycle whose post-shift mb equals 0.
  - CALC lasts at least 1 cycle (SrcB magnitude 0 → 1 CALC cycle).
  - Latency = CALC cycles + 3.
- Undefined: CALC always runs exactly MUL_W cycles. Product values are identical in both builds.

## Structure
- Package `mul_pkg` holds:
  - the state enum (IDLE, CALC, FIX, WB_LO, WB_HI);
  - `MUL_ITER` = 32;
  - the localparam for the counter width, $clog2(MUL_ITER).
- One sub-module, `mul_seq_dp`, contains the acc/mc/mb registers, the adder, the shifters and the sign fix.
  - It is controlled by load, step and fix strobes from the FSM in `mul_seq`.

## Test plan
- Unsigned, SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF, Start at T0 → ProdHi=0xFFFFFFFE, ProdLo=0x00000001; WriteLo at T34; WriteHi and Done at T35; Busy low at T36.
- Signed, SrcA=0xFFFFFFFF (−1), SrcB=0x00000001 → ProdHi=0xFFFFFFFF, ProdLo=0xFFFFFFFF.
- Signed, SrcA=SrcB=0x80000000 → ProdHi=0x40000000, ProdLo=0x00000000.
- Start re-pulsed at T5 with SrcA=2, SrcB=2 during a 3×4 unsigned op → result 0x0000000C; exactly one Done pulse; the second request is dropped.
- Reset asserted at T10 during CALC → at T11 Busy=0, ProdLo=ProdHi=0, state IDLE; no WriteLo or WriteHi pulse afterwards.
- Unsigned 7×3:
  - With `MUL_SEQ_EARLY_EXIT_EN`: CALC T1–T2, Done at T5.
  - Without it: Done at T35.
  - Both builds: ProdLo=0x00000015.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative multiply sequencer.
package mul_pkg;

  localparam int MUL_ITER = 32;
  localparam int CNT_W    = $clog2(MUL_ITER);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    FIX,
    WB_LO,
    WB_HI
  } state_t;

endpackage

// File: rtl/mul_seq_dp.sv
// Shift-add datapath: accumulator, shifted multiplicand, multiplier shifter,
// sign fix-up and the product latch. Driven by load/step/fix strobes.
module mul_seq_dp #(
  parameter int MUL_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  logic               sgn,
  input  logic [MUL_W-1:0]   src_a,
  input  logic [MUL_W-1:0]   src_b,
  output logic [2*MUL_W-1:0] prod,
  output logic               mb_last
);

  logic [2*MUL_W-1:0] acc_reg, acc_next;
  logic [2*MUL_W-1:0] mc_reg, mc_next;
  logic [2*MUL_W-1:0] prod_reg, prod_next;
  logic [MUL_W-1:0]   mb_reg, mb_next;
  logic               neg_reg, neg_next;
  logic [MUL_W-1:0]   abs_a, abs_b;

  // Magnitudes; the most negative value maps onto itself, which is correct unsigned.
  assign abs_a = (sgn && src_a[MUL_W-1]) ? -src_a : src_a;
  assign abs_b = (sgn && src_b[MUL_W-1]) ? -src_b : src_b;

  always_comb begin
    acc_next  = acc_reg;
    mc_next   = mc_reg;
    mb_next   = mb_reg;
    neg_next  = neg_reg;
    prod_next = prod_reg;
    if (load) begin
      acc_next = '0;
      mc_next  = {{MUL_W{1'b0}}, abs_a};
      mb_next  = abs_b;
      neg_next = sgn & (src_a[MUL_W-1] ^ src_b[MUL_W-1]);
    end else if (step) begin
      if (mb_reg[0]) acc_next = acc_reg + mc_reg;
      mc_next = mc_reg << 1;
      mb_next = mb_reg >> 1;
    end else if (fix) begin
      acc_next  = neg_reg ? ((~acc_reg) + 1'b1) : acc_reg;
      prod_next = acc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg  <= '0;
      mc_reg   <= '0;
      mb_reg   <= '0;
      neg_reg  <= 1'b0;
      prod_reg <= '0;
    end else begin
      acc_reg  <= acc_next;
      mc_reg   <= mc_next;
      mb_reg   <= mb_next;
      neg_reg  <= neg_next;
      prod_reg <= prod_next;
    end
  end

  assign prod    = prod_reg;
  // True when the multiplier will be zero after this cycle's shift.
  assign mb_last = ((mb_reg >> 1) == '0);

endmodule

// File: rtl/mul_seq.sv
// Iterative 32x32->64 UMULL/SMULL sequencer with two-cycle low/high write-back.
// Optional build macro MUL_SEQ_EARLY_EXIT_EN ends CALC once the multiplier is exhausted.
module mul_seq
  import mul_pkg::*;
#(
  parameter int MUL_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [MUL_W-1:0] SrcA,
  input  logic [MUL_W-1:0] SrcB,
  output logic             Busy,
  output logic             WriteLo,
  output logic             WriteHi,
  output logic             Done,
  output logic [MUL_W-1:0] ProdLo,
  output logic [MUL_W-1:0] ProdHi
);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               load, step, fix;
  logic               mb_last, exit_calc;
  logic               busy_reg, write_lo_reg, write_hi_reg, done_reg;
  logic [2*MUL_W-1:0] prod;

`ifdef MUL_SEQ_EARLY_EXIT_EN
  assign exit_calc = (cnt_reg == '0) || mb_last;
`else
  assign exit_calc = (cnt_reg == '0);
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    step       = 1'b0;
    fix        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Start) begin
          load       = 1'b1;
          cnt_next   = CNT_W'(MUL_W - 1);
          state_next = CALC;
        end
      end
      CALC: begin
        step     = 1'b1;
        cnt_next = cnt_reg - CNT_W'(1);
        if (exit_calc) state_next = FIX;
      end
      FIX: begin
        fix        = 1'b1;
        state_next = WB_LO;
      end
      WB_LO:   state_next = WB_HI;
      WB_HI:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they align with the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      busy_reg     <= 1'b0;
      write_lo_reg <= 1'b0;
      write_hi_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      busy_reg     <= (state_next != IDLE);
      write_lo_reg <= (state_next == WB_LO);
      write_hi_reg <= (state_next == WB_HI);
      done_reg     <= (state_next == WB_HI);
    end
  end

  mul_seq_dp #(.MUL_W(MUL_W)) u_dp (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .fix     (fix),
    .sgn     (Signed),
    .src_a   (SrcA),
    .src_b   (SrcB),
    .prod    (prod),
    .mb_last (mb_last)
  );

  assign Busy    = busy_reg;
  assign WriteLo = write_lo_reg;
  assign WriteHi = write_hi_reg;
  assign Done    = done_reg;
  assign ProdLo  = prod[MUL_W-1:0];
  assign ProdHi  = prod[2*MUL_W-1:MUL_W];

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed plan cases plus randomized
// back-to-back operations against a plain-arithmetic product/latency model.
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic        Signed = 1'b0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        Busy, WriteLo, WriteHi, Done;
  logic [31:0] ProdLo, ProdHi;

  int checks = 0;
  int errors = 0;

  mul_seq #(.MUL_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .Signed  (Signed),
    .SrcA    (SrcA),
    .SrcB    (SrcB),
    .Busy    (Busy),
    .WriteLo (WriteLo),
    .WriteHi (WriteHi),
    .Done    (Done),
    .ProdLo  (ProdLo),
    .ProdHi  (ProdHi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (Busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    checks++; if (WriteLo !== 1'b0) begin errors++; $display("FAIL reset_writelo got %b want 0", WriteLo); end
    checks++; if (WriteHi !== 1'b0) begin errors++; $display("FAIL reset_writehi got %b want 0", WriteHi); end
    checks++; if (Done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", Done); end
    checks++; if (ProdLo !== 32'h0) begin errors++; $display("FAIL reset_prodlo got %h want 0", ProdLo); end
    checks++; if (ProdHi !== 32'h0) begin errors++; $display("FAIL reset_prodhi got %h want 0", ProdHi); end
    reset = 1'b0;
    tick();
    $display("reset: outputs checked");
  endtask

  // One request; repulse_at re-asserts Start (SrcA=SrcB=2) during cycle n of the op,
  // tail watches extra idle cycles for spurious activity.
  task automatic do_op(input bit sg, input logic [31:0] a, input logic [31:0] b,
                       input int repulse_at, input int tail, input string tag);
    logic [63:0] expv, got;
    logic [31:0] mag;
    int calc, lat, lo_at, hi_at, done_at, lo_cnt, hi_cnt, done_cnt, busy_off, extra;
    if (sg) expv = 64'(longint'($signed(a)) * longint'($signed(b)));
    else    expv = {32'h0, a} * {32'h0, b};
    mag = (sg && b[31]) ? (32'h0 - b) : b;
`ifdef MUL_SEQ_EARLY_EXIT_EN
    calc = 0;
    while (mag != 32'h0) begin mag = mag >> 1; calc++; end
    if (calc == 0) calc = 1;
`else
    calc = 32;
`endif
    lat = calc + 3;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL %s busy_t0 got %b want 0", tag, Busy); end
    Start = 1'b1; Signed = sg; SrcA = a; SrcB = b;
    tick();
    Start = 1'b0; SrcA = $urandom; SrcB = $urandom; Signed = 1'($urandom);
    lo_at = -1; hi_at = -1; done_at = -1; busy_off = -1;
    lo_cnt = 0; hi_cnt = 0; done_cnt = 0;
    for (int n = 1; n <= 60; n++) begin
      if (n == repulse_at) begin Start = 1'b1; SrcA = 32'd2; SrcB = 32'd2; Signed = 1'b0; end
      else Start = 1'b0;
      if (WriteLo === 1'b1) begin if (lo_at < 0) lo_at = n; lo_cnt++; end
      if (WriteHi === 1'b1) begin if (hi_at < 0) hi_at = n; hi_cnt++; end
      if (Done === 1'b1)    begin if (done_at < 0) done_at = n; done_cnt++; end
      if (Busy !== 1'b1) begin busy_off = n; break; end
      tick();
    end
    Start = 1'b0;
    got = {ProdHi, ProdLo};
    checks++; if (got !== expv) begin errors++; $display("FAIL %s product got %h want %h", tag, got, expv); end
    checks++; if (lo_at != lat - 1) begin errors++; $display("FAIL %s writelo_cycle got %0d want %0d", tag, lo_at, lat - 1); end
    checks++; if (hi_at != lat) begin errors++; $display("FAIL %s writehi_cycle got %0d want %0d", tag, hi_at, lat); end
    checks++; if (done_at != lat) begin errors++; $display("FAIL %s done_cycle got %0d want %0d", tag, done_at, lat); end
    checks++; if (lo_cnt != 1 || hi_cnt != 1 || done_cnt != 1) begin
      errors++; $display("FAIL %s strobe_count got lo=%0d hi=%0d done=%0d want 1 each", tag, lo_cnt, hi_cnt, done_cnt);
    end
    checks++; if (busy_off != lat + 1) begin errors++; $display("FAIL %s busy_fall got %0d want %0d", tag, busy_off, lat + 1); end
    extra = 0;
    for (int t = 0; t < tail; t++) begin
      tick();
      if (Busy !== 1'b0 || WriteLo !== 1'b0 || WriteHi !== 1'b0 || Done !== 1'b0) extra++;
    end
    if (tail > 0) begin
      checks++; if (extra != 0) begin errors++; $display("FAIL %s idle_tail got %0d active cycles want 0", tag, extra); end
    end
    $display("op %s sg=%0d a=%h b=%h prod=%h want=%h done@%0d", tag, sg, a, b, got, expv, done_at);
  endtask

  task automatic test_plan();
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "umax");
    do_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, "sneg1");
    do_op(1'b1, 32'h8000_0000, 32'h8000_0000, 0, 0, "smin2");
    do_op(1'b0, 32'd3, 32'd4, 5, 4, "repulse");
`ifdef MUL_SEQ_EARLY_EXIT_EN
    do_op(1'b0, 32'd5, 32'd6, 6, 4, "start_in_wbhi");
`else
    do_op(1'b0, 32'd5, 32'd6, 35, 4, "start_in_wbhi");
`endif
    do_op(1'b0, 32'd7, 32'd3, 0, 0, "u7x3");
  endtask

  task automatic test_reset_mid_calc();
    int act;
    Start = 1'b1; Signed = 1'b0; SrcA = 32'hFFFF_FFFF; SrcB = 32'hFFFF_FFFF;
    tick();
    Start = 1'b0;
    for (int n = 1; n < 10; n++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (Busy !== 1'b0)    begin errors++; $display("FAIL midreset_busy got %b want 0", Busy); end
    checks++; if (ProdLo !== 32'h0) begin errors++; $display("FAIL midreset_prodlo got %h want 0", ProdLo); end
    checks++; if (ProdHi !== 32'h0) begin errors++; $display("FAIL midreset_prodhi got %h want 0", ProdHi); end
    act = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (Busy !== 1'b0 || WriteLo !== 1'b0 || WriteHi !== 1'b0 || Done !== 1'b0) act++;
    end
    checks++; if (act != 0) begin errors++; $display("FAIL midreset_quiet got %0d active cycles want 0", act); end
    $display("midreset: checked quiet after reset at T10");
  endtask

  task automatic test_back_to_back();
    logic [31:0] corner [5];
    logic [31:0] a, b;
    bit sg;
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'h7FFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'hFFFF_FFFF;
    for (int i = 0; i < 20; i++) begin
      sg = 1'($urandom);
      a = ($urandom_range(3) == 0) ? corner[$urandom_range(4)] : $urandom;
      b = ($urandom_range(3) == 0) ? corner[$urandom_range(4)] : $urandom;
      if ($urandom_range(3) == 0) b = b >> $urandom_range(31);
      do_op(sg, a, b, 0, 0, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_plan();
    test_reset_mid_calc();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
